// File: rtl/mont_tx_pkg.sv
// Shared types and helpers for the Montgomery result transmit path.
// Contents: tx_state_t FSM encoding, cnt_width() counter width helper.
package mont_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } tx_state_t;

  // Counter width for n chunks; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/mont_chunk_counter.sv
// Chunk index counter for the result transmitter.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_ena        global enable; all state holds when low
//   i_clr        synchronous clear to zero (wins over i_inc)
//   i_inc        advance by one
//   o_tc_c       count is at the final chunk (N-1)
//   o_pre_tc_c   count is one before the final chunk (N-2)
module mont_chunk_counter
  import mont_tx_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ena,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_tc_c,
  output logic o_pre_tc_c
);

  localparam int unsigned CW = cnt_width(N);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      if (i_clr)      r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tc_c     = (r_cnt == CW'(N - 1));
  assign o_pre_tc_c = (r_cnt == CW'(N - 2));

endmodule

// File: rtl/mont_result_tx.sv
// Captures a WIDTH-bit Montgomery result in one cycle and streams it out
// LSB chunk first, CHUNK bits at a time, over a valid/ready interface.
// Optional feature: define MONT_RESULT_TX_PARITY_EN to add out_parity,
// the XOR of the captured result, shown alongside the final chunk.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ena                 global enable; state and outputs hold when low
//   clear               synchronous abort back to IDLE
//   load, R_i           capture strobe and result value
//   out_valid/ready     chunk handshake
//   out_data, out_last  current chunk and final-chunk marker
//   busy                capture until last chunk accepted
//   done                one-cycle pulse after last chunk accepted
//   out_parity          (parity build only) result parity on final chunk
module mont_result_tx
  import mont_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] R_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef MONT_RESULT_TX_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;

  tx_state_t        r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_valid;
  logic             r_last;
  logic             r_busy;
  logic             r_done;

  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_tc;
  logic w_pre_tc;

  // Counter restarts on capture or abort, advances on each accepted chunk.
  assign w_cnt_clr = clear || ((r_state == IDLE) && load);
  assign w_cnt_inc = (r_state == SEND) && out_ready;

  mont_chunk_counter #(
    .N (NCHUNK)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_ena      (ena),
    .i_clr      (w_cnt_clr),
    .i_inc      (w_cnt_inc),
    .o_tc_c     (w_tc),
    .o_pre_tc_c (w_pre_tc)
  );

`ifdef MONT_RESULT_TX_PARITY_EN
  logic r_par_cap;
  logic r_par_out;
`endif

  // Transfer FSM; out_last is registered one step ahead using the
  // pre-terminal flag so it lines up with the final chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MONT_RESULT_TX_PARITY_EN
      r_par_cap <= 1'b0;
      r_par_out <= 1'b0;
`endif
    end else if (ena) begin
      if (clear) begin
        r_state   <= IDLE;
        r_shreg   <= '0;
        r_valid   <= 1'b0;
        r_last    <= 1'b0;
        r_busy    <= 1'b0;
        r_done    <= 1'b0;
`ifdef MONT_RESULT_TX_PARITY_EN
        r_par_cap <= 1'b0;
        r_par_out <= 1'b0;
`endif
      end else begin
        case (r_state)
          IDLE: begin
            r_done <= 1'b0;
            if (load) begin
              r_state   <= SEND;
              r_shreg   <= R_i;
              r_valid   <= 1'b1;
              r_busy    <= 1'b1;
              r_last    <= 1'b0;
`ifdef MONT_RESULT_TX_PARITY_EN
              r_par_cap <= ^R_i;
              r_par_out <= 1'b0;
`endif
            end
          end
          SEND: begin
            if (out_ready) begin
              r_shreg <= r_shreg >> CHUNK;
              if (w_tc) begin
                r_state   <= FIN;
                r_valid   <= 1'b0;
                r_busy    <= 1'b0;
                r_last    <= 1'b0;
                r_done    <= 1'b1;
`ifdef MONT_RESULT_TX_PARITY_EN
                r_par_out <= 1'b0;
`endif
              end else begin
                r_last    <= w_pre_tc;
`ifdef MONT_RESULT_TX_PARITY_EN
                r_par_out <= w_pre_tc & r_par_cap;
`endif
              end
            end
          end
          FIN: begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_shreg[CHUNK-1:0];
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
`ifdef MONT_RESULT_TX_PARITY_EN
  assign out_parity = r_par_out;
`endif

endmodule
